pedestrian_signals: RTL and testbench
=====================================

# pedestrian_signals

Downstream consumer of the four-way `traffic_lights` controller outputs. It drives one pedestrian crossing per approach, in the order S, W, N, E. Push-button requests are latched, and each crossing is served at the next onset of green on its own approach. The block runs a timed WALK phase, then a flashing don't-walk clearance phase, with a per-crossing countdown. It also watches the incoming light codes for conflicting greens or illegal codes and forces every crossing to a safe state when it finds one.

## Interface
Parameters:
- `WALK_CYC`, default 20: WALK phase length in clock cycles; legal range 1 to 2^CNT_W-1.
- `FLASH_CYC`, default 10: flashing clearance length in clock cycles; legal range 1 to 2^CNT_W-1.
- `CNT_W`, default 8: width of each countdown field.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `S_light`, `W_light`, `N_light`, `E_light` in 2 each: light codes from `traffic_lights`. Codes are 00 red, 01 yellow, 10 green, 11 illegal.
- `ped_req` in 4: button inputs, bit0=S, bit1=W, bit2=N, bit3=E; level-sampled each cycle.
- `walk` out 4: steady WALK per crossing.
- `flash` out 4: flashing don't-walk (clearance) per crossing.
- `req_pending` out 4: latched request not yet served.
- `countdown` out 4*CNT_W: field i is `[i*CNT_W +: CNT_W]`; remaining cycles of the current phase, 0 when idle.
- `fault` out 1: sticky conflict flag.

## Operation
- Each crossing runs an independent FSM with states IDLE, WAIT, WALK, FLASH.
- Onset of green on approach i: the sampled light is 10 and the registered previous code is not 10.
- The previous-code register resets to 00 (red), so green present immediately after reset counts as an onset.
- `req_pending[i]` is set whenever `ped_req[i]`=1, in any state.
- `req_pending[i]` is cleared on the edge that enters WALK. A request asserted on that same edge is dropped, because it is being served.
- IDLE -> WAIT when `req_pending[i]`=1.
- WAIT -> WALK only on a green onset. Green already in progress when WAIT is entered does not qualify; the crossing waits for the next onset.
- WALK lasts WALK_CYC cycles, then goes to FLASH.
- If the approach leaves green during WALK, go to FLASH on the next edge.
- FLASH lasts FLASH_CYC cycles regardless of the light, then returns to IDLE.
- A request latched during WALK/FLASH causes IDLE -> WAIT on the edge after FLASH ends.
- Output decode: `walk`=1 only in WALK; `flash`=1 only in FLASH.
- Countdown values:
  - WALK: WALK_CYC down to 1.
  - FLASH: FLASH_CYC down to 1.
  - IDLE/WAIT: 0.
- The countdown never underflows or wraps.
- Fault detection, evaluated every cycle on the sampled inputs:
  - (S or N green) while (E or W green), or
  - any input equal to 11.
- On fault detection, `fault`=1 from the next edge until reset.
- While `fault`=1:
  - all FSMs are held in IDLE;
  - `walk`, `flash`, `countdown` and `req_pending` are all 0;
  - `ped_req` is ignored.

## Timing
- All outputs are registered. Reset drives every output to 0 and every FSM to IDLE.
- An asynchronous reset mid-phase aborts immediately, with no clearance phase.
- Onset detected at edge t gives `walk`=1 and countdown=WALK_CYC from edge t.
- A request at edge t gives `req_pending`=1 after edge t and the WAIT state after edge t+1.
- A request arriving in the same sampled cycle as an onset is not served by that onset.
- Exactly one of the following holds per crossing at any time: `walk`=1, or `flash`=1, or both 0.
- Simultaneous fault and onset: fault wins, and no WALK is entered.

## Structure
- Shared package `traffic_pkg` holds:
  - light codes `LIGHT_RED`, `LIGHT_YELLOW`, `LIGHT_GREEN`, `LIGHT_BAD`;
  - approach indices S=0, W=1, N=2, E=3;
  - crossing state encoding.
- Sub-module `ped_crossing_fsm` holds one crossing: previous-light register, pending flag, FSM and countdown. It is instantiated four times.
- The top level holds the fault detector and the kill/hold broadcast to the four crossings.

## Test plan
- Reset, then red on all approaches, no requests -> all outputs 0 for 100 cycles.
- Pulse `ped_req[0]` while S is red, then S turns green -> `walk[0]`=1 for exactly 20 cycles, then `flash[0]`=1 for 10 cycles, `countdown[0]` running 20..1 then 10..1, `req_pending[0]` cleared at WALK entry.
- Request while N is already green mid-phase -> stays in WAIT with no walk until N goes non-green and back to green.
- S leaves green at WALK cycle 5 -> FLASH starts on the next edge with countdown 10, then IDLE.
- N and E green simultaneously, or any input equal to 11, during an active WALK -> `fault`=1 next edge and all outputs 0. Only `rst_n` clears this.
- Assert `rst_n`=0 mid-FLASH, asynchronously between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared definitions for the four-way traffic light controller
//               and its pedestrian crossing consumer: light codes, approach
//               indices and the crossing state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Light codes as driven by traffic_lights
    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;
    localparam logic [1:0] LIGHT_BAD    = 2'b11;

    // Approach indices; also the bit position of each crossing on the bus
    localparam int c_appr_s   = 0;
    localparam int c_appr_w   = 1;
    localparam int c_appr_n   = 2;
    localparam int c_appr_e   = 3;
    localparam int c_num_appr = 4;

    // Per-crossing state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WALK  = 2'd2,
        ST_FLASH = 2'd3
    } xing_state_t;

    function automatic logic is_green(input logic [1:0] code);
        return (code == LIGHT_GREEN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pedestrian_signals_if.sv
`default_nettype none
// ============================================================================
// Module      : pedestrian_signals_if
// Description : Bundle between the traffic light side and the pedestrian
//               signal block: incoming light codes and buttons, outgoing
//               per-crossing signal heads, countdowns and fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface pedestrian_signals_if #(
    parameter int CNT_W = 8
);
    logic [1:0]         S_light;
    logic [1:0]         W_light;
    logic [1:0]         N_light;
    logic [1:0]         E_light;
    logic [3:0]         ped_req;
    logic [3:0]         walk;
    logic [3:0]         flash;
    logic [3:0]         req_pending;
    logic [4*CNT_W-1:0] countdown;
    logic               fault;

    // Traffic/button side: supplies lights and requests, observes signals
    modport master (
        output S_light, W_light, N_light, E_light, ped_req,
        input  walk, flash, req_pending, countdown, fault
    );

    // Pedestrian signal block side
    modport slave (
        input  S_light, W_light, N_light, E_light, ped_req,
        output walk, flash, req_pending, countdown, fault
    );
endinterface
`default_nettype wire

// File: rtl/ped_crossing_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ped_crossing_fsm
// Description : One pedestrian crossing. Latches button requests, waits for
//               the next green onset on its approach, then runs a timed WALK
//               phase followed by a flashing clearance phase with countdown.
//               i_hold forces the crossing to IDLE and drops any request.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_crossing_fsm
    import traffic_pkg::*;
#(
    parameter int WALK_CYC  = 20,
    parameter int FLASH_CYC = 10,
    parameter int CNT_W     = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [1:0]       i_light,
    input  wire logic             i_ped_req,
    input  wire logic             i_hold,
    output logic                  o_walk,
    output logic                  o_flash,
    output logic                  o_req_pending,
    output logic [CNT_W-1:0]      o_countdown
);

    localparam logic [CNT_W-1:0] c_walk_load  = CNT_W'(WALK_CYC);
    localparam logic [CNT_W-1:0] c_flash_load = CNT_W'(FLASH_CYC);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    xing_state_t      r_state;
    xing_state_t      w_state_nxt;
    logic [1:0]       r_prev_light;
    logic             r_pending;
    logic             w_pending_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_walk;
    logic             r_flash;
    logic             w_green;
    logic             w_onset;

    // Onset means green now but not green last cycle; the history register
    // starts at red so green straight out of reset is an onset.
    assign w_green = is_green(i_light);
    assign w_onset = w_green && !is_green(r_prev_light);

    // State, countdown, request latch and registered signal heads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_prev_light <= LIGHT_RED;
            r_pending    <= 1'b0;
            r_count      <= '0;
            r_walk       <= 1'b0;
            r_flash      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_light <= i_light;
            r_pending    <= w_pending_nxt;
            r_count      <= w_count_nxt;
            r_walk       <= (w_state_nxt == ST_WALK);
            r_flash      <= (w_state_nxt == ST_FLASH);
        end
    end

    // Next-state, countdown and request-latch logic
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_pending_nxt = r_pending | i_ped_req;

        if (i_hold) begin
            w_state_nxt   = ST_IDLE;
            w_count_nxt   = '0;
            w_pending_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_count_nxt = '0;
                    if (r_pending) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    w_count_nxt = '0;
                    if (w_onset) begin
                        // Request being served now; a press on this edge is absorbed
                        w_state_nxt   = ST_WALK;
                        w_count_nxt   = c_walk_load;
                        w_pending_nxt = 1'b0;
                    end
                end
                ST_WALK: begin
                    // Losing green cuts the walk short; clearance always runs in full
                    if (!w_green || (r_count <= c_one)) begin
                        w_state_nxt = ST_FLASH;
                        w_count_nxt = c_flash_load;
                    end else begin
                        w_count_nxt = r_count - c_one;
                    end
                end
                ST_FLASH: begin
                    if (r_count <= c_one) begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count - c_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    assign o_walk        = r_walk;
    assign o_flash       = r_flash;
    assign o_req_pending = r_pending;
    assign o_countdown   = r_count;

endmodule
`default_nettype wire

// File: rtl/pedestrian_signals.sv
`default_nettype none
// ============================================================================
// Module      : pedestrian_signals
// Description : Four pedestrian crossings (S, W, N, E) driven from the
//               traffic light codes. Detects conflicting greens or illegal
//               codes, latches a sticky fault and holds every crossing in a
//               safe idle state until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pedestrian_signals
    import traffic_pkg::*;
#(
    parameter int WALK_CYC  = 20,
    parameter int FLASH_CYC = 10,
    parameter int CNT_W     = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    pedestrian_signals_if.slave bus
);

    logic [1:0]         w_light [c_num_appr];
    logic [3:0]         w_walk;
    logic [3:0]         w_flash;
    logic [3:0]         w_pending;
    logic [4*CNT_W-1:0] w_countdown;
    logic               w_conflict;
    logic               w_bad_code;
    logic               w_fault_now;
    logic               w_hold;
    logic               r_fault;

    assign w_light[c_appr_s] = bus.S_light;
    assign w_light[c_appr_w] = bus.W_light;
    assign w_light[c_appr_n] = bus.N_light;
    assign w_light[c_appr_e] = bus.E_light;

    // North-south green together with east-west green, or any illegal code
    assign w_conflict  = (is_green(bus.S_light) || is_green(bus.N_light)) &&
                         (is_green(bus.E_light) || is_green(bus.W_light));
    assign w_bad_code  = (bus.S_light == LIGHT_BAD) || (bus.W_light == LIGHT_BAD) ||
                         (bus.N_light == LIGHT_BAD) || (bus.E_light == LIGHT_BAD);
    assign w_fault_now = w_conflict || w_bad_code;

    // The live detection is included so a fault beats a same-cycle green onset
    assign w_hold = r_fault || w_fault_now;

    // Sticky fault flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_fault_now) begin
            r_fault <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < c_num_appr; gi++) begin : g_xing
            ped_crossing_fsm #(
                .WALK_CYC  (WALK_CYC),
                .FLASH_CYC (FLASH_CYC),
                .CNT_W     (CNT_W)
            ) u_xing (
                .clk           (clk),
                .rst_n         (rst_n),
                .i_light       (w_light[gi]),
                .i_ped_req     (bus.ped_req[gi]),
                .i_hold        (w_hold),
                .o_walk        (w_walk[gi]),
                .o_flash       (w_flash[gi]),
                .o_req_pending (w_pending[gi]),
                .o_countdown   (w_countdown[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign bus.walk        = w_walk;
    assign bus.flash       = w_flash;
    assign bus.req_pending = w_pending;
    assign bus.countdown   = w_countdown;
    assign bus.fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pedestrian_signals.sv
`default_nettype none
// ============================================================================
// Module      : tb_pedestrian_signals
// Description : Directed self-checking bench for pedestrian_signals with
//               WALK_CYC=20, FLASH_CYC=10, CNT_W=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pedestrian_signals;
    import traffic_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pedestrian_signals_if #(.CNT_W(8)) bus ();

    pedestrian_signals #(
        .WALK_CYC  (20),
        .FLASH_CYC (10),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // Advance one edge and settle just after it
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lights(input logic [1:0] s, input logic [1:0] w,
                              input logic [1:0] n, input logic [1:0] e);
        bus.S_light = s;
        bus.W_light = w;
        bus.N_light = n;
        bus.E_light = e;
    endtask

    // Press one button for one sampled cycle, then leave the crossing in WAIT
    task automatic press_to_wait(input int idx);
        bus.ped_req = 4'b0001 << idx;
        tick();
        bus.ped_req = 4'b0000;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_lights(LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_RED);
        bus.ped_req = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_lights(LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_RED);
        bus.ped_req = 4'b0000;
        tick(2);
        total++;
        if ({bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 100; k++) begin
            tick();
            total++;
            if ({bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault} !== '0) begin
                bad++;
                $display("FAIL idle_cycle%0d: got %h required 0", k,
                         {bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault});
            end
        end
    endtask

    task automatic test_walk_cycle();
        bus.ped_req = 4'b0001;
        tick();
        bus.ped_req = 4'b0000;
        total++;
        if (bus.req_pending !== 4'b0001 || bus.walk !== 4'b0000) begin
            bad++;
            $display("FAIL req_latch: pending=%b walk=%b required pending=0001 walk=0000",
                     bus.req_pending, bus.walk);
        end
        tick(4);
        total++;
        if (bus.req_pending !== 4'b0001 || bus.walk !== 4'b0000) begin
            bad++;
            $display("FAIL wait_red: pending=%b walk=%b required pending=0001 walk=0000",
                     bus.req_pending, bus.walk);
        end
        bus.S_light = LIGHT_GREEN;
        tick();
        total++;
        if ({bus.walk, bus.flash, bus.req_pending, bus.countdown} !== {4'b0001, 4'b0000, 4'b0000, 32'd20}) begin
            bad++;
            $display("FAIL walk_entry: walk=%b flash=%b pending=%b cd=%h required 0001/0000/0000/00000014",
                     bus.walk, bus.flash, bus.req_pending, bus.countdown);
        end
        for (int k = 1; k < 20; k++) begin
            tick();
            total++;
            if ({bus.walk, bus.flash, bus.countdown} !== {4'b0001, 4'b0000, 32'(20 - k)}) begin
                bad++;
                $display("FAIL walk_count%0d: walk=%b flash=%b cd=%0d required walk=0001 cd=%0d",
                         k, bus.walk, bus.flash, bus.countdown, 20 - k);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if ({bus.walk, bus.flash, bus.countdown} !== {4'b0000, 4'b0001, 32'(10 - k)}) begin
                bad++;
                $display("FAIL flash_count%0d: walk=%b flash=%b cd=%0d required flash=0001 cd=%0d",
                         k, bus.walk, bus.flash, bus.countdown, 10 - k);
            end
        end
        tick();
        total++;
        if ({bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault} !== '0) begin
            bad++;
            $display("FAIL walk_done_idle: got %h required 0",
                     {bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault});
        end
        bus.S_light = LIGHT_RED;
        tick();
    endtask

    task automatic test_green_in_progress();
        bus.N_light = LIGHT_GREEN;
        tick(2);
        press_to_wait(2);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (bus.walk !== 4'b0000 || bus.req_pending !== 4'b0100) begin
                bad++;
                $display("FAIL green_held%0d: walk=%b pending=%b required walk=0000 pending=0100",
                         k, bus.walk, bus.req_pending);
            end
        end
        bus.N_light = LIGHT_YELLOW;
        tick(2);
        bus.N_light = LIGHT_GREEN;
        tick();
        total++;
        if ({bus.walk, bus.req_pending, bus.countdown} !== {4'b0100, 4'b0000, 32'h0014_0000}) begin
            bad++;
            $display("FAIL n_reonset_walk: walk=%b pending=%b cd=%h required 0100/0000/00140000",
                     bus.walk, bus.req_pending, bus.countdown);
        end
        tick(2);
        bus.N_light = LIGHT_RED;
        tick();
        total++;
        if ({bus.walk, bus.flash, bus.countdown} !== {4'b0000, 4'b0100, 32'h000A_0000}) begin
            bad++;
            $display("FAIL n_cut_flash: walk=%b flash=%b cd=%h required 0000/0100/000a0000",
                     bus.walk, bus.flash, bus.countdown);
        end
        tick(10);
        total++;
        if ({bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault} !== '0) begin
            bad++;
            $display("FAIL n_back_idle: got %h required 0",
                     {bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault});
        end
    endtask

    task automatic test_leave_green();
        press_to_wait(0);
        bus.S_light = LIGHT_GREEN;
        tick();
        tick(4);
        total++;
        if ({bus.walk, bus.countdown} !== {4'b0001, 32'd16}) begin
            bad++;
            $display("FAIL s_walk_cycle5: walk=%b cd=%0d required walk=0001 cd=16",
                     bus.walk, bus.countdown);
        end
        bus.S_light = LIGHT_YELLOW;
        tick();
        total++;
        if ({bus.walk, bus.flash, bus.countdown} !== {4'b0000, 4'b0001, 32'd10}) begin
            bad++;
            $display("FAIL s_leave_flash: walk=%b flash=%b cd=%0d required 0000/0001/10",
                     bus.walk, bus.flash, bus.countdown);
        end
        tick(9);
        total++;
        if ({bus.flash, bus.countdown} !== {4'b0001, 32'd1}) begin
            bad++;
            $display("FAIL s_flash_last: flash=%b cd=%0d required flash=0001 cd=1",
                     bus.flash, bus.countdown);
        end
        tick();
        total++;
        if ({bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault} !== '0) begin
            bad++;
            $display("FAIL s_leave_idle: got %h required 0",
                     {bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault});
        end
        bus.S_light = LIGHT_RED;
        tick();
    endtask

    task automatic test_conflict_fault();
        press_to_wait(2);
        bus.N_light = LIGHT_GREEN;
        tick();
        total++;
        if (bus.walk !== 4'b0100) begin
            bad++;
            $display("FAIL fault_pre_walk: walk=%b required 0100", bus.walk);
        end
        tick(2);
        bus.E_light = LIGHT_GREEN;
        bus.ped_req = 4'b1111;
        tick();
        total++;
        if (bus.fault !== 1'b1 || {bus.walk, bus.flash, bus.req_pending, bus.countdown} !== '0) begin
            bad++;
            $display("FAIL conflict_fault: fault=%b rest=%h required fault=1 rest=0",
                     bus.fault, {bus.walk, bus.flash, bus.req_pending, bus.countdown});
        end
        tick(3);
        set_lights(LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_RED);
        tick(3);
        bus.ped_req = 4'b0000;
        tick();
        total++;
        if (bus.fault !== 1'b1 || {bus.walk, bus.flash, bus.req_pending, bus.countdown} !== '0) begin
            bad++;
            $display("FAIL fault_sticky: fault=%b rest=%h required fault=1 rest=0",
                     bus.fault, {bus.walk, bus.flash, bus.req_pending, bus.countdown});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault} !== '0) begin
            bad++;
            $display("FAIL fault_reset_clear: got %h required 0",
                     {bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_illegal_code();
        bus.W_light = LIGHT_BAD;
        tick();
        total++;
        if (bus.fault !== 1'b1) begin
            bad++;
            $display("FAIL illegal_idle_fault: fault=%b required 1", bus.fault);
        end
        do_reset();
        press_to_wait(1);
        bus.W_light = LIGHT_GREEN;
        tick(2);
        total++;
        if ({bus.walk, bus.countdown} !== {4'b0010, 32'h0000_1300}) begin
            bad++;
            $display("FAIL w_walk_running: walk=%b cd=%h required 0010/00001300",
                     bus.walk, bus.countdown);
        end
        bus.W_light = LIGHT_BAD;
        tick();
        total++;
        if (bus.fault !== 1'b1 || {bus.walk, bus.flash, bus.req_pending, bus.countdown} !== '0) begin
            bad++;
            $display("FAIL illegal_walk_fault: fault=%b rest=%h required fault=1 rest=0",
                     bus.fault, {bus.walk, bus.flash, bus.req_pending, bus.countdown});
        end
        do_reset();
    endtask

    task automatic test_fault_vs_onset();
        press_to_wait(0);
        bus.S_light = LIGHT_GREEN;
        bus.E_light = LIGHT_GREEN;
        tick();
        total++;
        if (bus.fault !== 1'b1 || bus.walk !== 4'b0000 || bus.countdown !== '0) begin
            bad++;
            $display("FAIL fault_beats_onset: fault=%b walk=%b cd=%h required 1/0000/0",
                     bus.fault, bus.walk, bus.countdown);
        end
        do_reset();
    endtask

    task automatic test_async_reset_flash();
        press_to_wait(3);
        bus.E_light = LIGHT_GREEN;
        tick(20);
        tick(4);
        total++;
        if ({bus.walk, bus.flash, bus.countdown} !== {4'b0000, 4'b1000, 32'h0700_0000}) begin
            bad++;
            $display("FAIL e_mid_flash: walk=%b flash=%b cd=%h required 0000/1000/07000000",
                     bus.walk, bus.flash, bus.countdown);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault} !== '0) begin
            bad++;
            $display("FAIL async_reset_flash: got %h required 0",
                     {bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault});
        end
        set_lights(LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_RED);
        #2 rst_n = 1'b1;
        tick();
        total++;
        if ({bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault} !== '0) begin
            bad++;
            $display("FAIL after_async_reset: got %h required 0",
                     {bus.walk, bus.flash, bus.req_pending, bus.countdown, bus.fault});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_lights(LIGHT_RED, LIGHT_RED, LIGHT_RED, LIGHT_RED);
        bus.ped_req = 4'b0000;

        test_reset();
        test_idle();
        test_walk_cycle();
        test_green_in_progress();
        test_leave_green();
        test_conflict_fault();
        test_illegal_code();
        test_fault_vs_onset();
        test_async_reset_flash();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
